// File: rtl/trig_wave_capture_pkg.sv
`default_nettype none
// ============================================================================
// trig_wave_capture_pkg : capture FSM states, trigger modes, counter sizing
// Rev 1.0
// ============================================================================
package trig_wave_capture_pkg;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_WAIT   = 2'b10
  } cap_state_e;

  localparam logic [1:0] TRIG_RISING  = 2'b00;
  localparam logic [1:0] TRIG_FALLING = 2'b01;
  localparam logic [1:0] TRIG_FREE    = 2'b10;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/trig_wave_capture_if.sv
`default_nettype none
// ============================================================================
// trig_wave_capture_if : sample stream, trigger config and bank-RAM write bus
// Rev 1.0
// ============================================================================
interface trig_wave_capture_if #(
  parameter int SAMPLE_W = 16,
  parameter int OUT_W    = 8,
  parameter int ADDR_W   = 8
);
  logic                       capture_en;
  logic [1:0]                 trig_mode;
  logic signed [SAMPLE_W-1:0] trig_threshold;
  logic                       new_sample_ready;
  logic signed [SAMPLE_W-1:0] new_sample_in;
  logic                       wave_display_idle;
  logic [ADDR_W:0]            write_address;
  logic                       write_enable;
  logic [OUT_W-1:0]           write_sample;
  logic                       read_index;
  logic                       frame_done;
  logic                       auto_triggered;

  modport master (
    input  capture_en, trig_mode, trig_threshold, new_sample_ready,
           new_sample_in, wave_display_idle,
    output write_address, write_enable, write_sample, read_index,
           frame_done, auto_triggered
  );

  modport slave (
    output capture_en, trig_mode, trig_threshold, new_sample_ready,
           new_sample_in, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index,
           frame_done, auto_triggered
  );
endinterface
`default_nettype wire

// File: rtl/trig_wave_capture_trigger_detect.sv
`default_nettype none
// ============================================================================
// trig_wave_capture_trigger_detect : sample pipe, config latch, edge compare
// Rev 1.0
// ============================================================================
module trig_wave_capture_trigger_detect
  import trig_wave_capture_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_ready_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic                       cfg_load_i,
  input  logic [1:0]                 trig_mode_i,
  input  logic signed [SAMPLE_W-1:0] trig_threshold_i,
  output logic                       sample_valid_o,
  output logic                       trig_hit_o,
  output logic signed [SAMPLE_W-1:0] curr_o
);

  logic signed [SAMPLE_W-1:0] curr_q, prev_q, thr_q;
  logic [1:0]                 mode_q;
  logic                       valid_q;
  logic                       boot_q;
  logic                       prev_above, curr_above, edge_hit;

  // boot_q makes the first clock after reset release load the config
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      curr_q  <= '0;
      prev_q  <= '0;
      thr_q   <= '0;
      mode_q  <= TRIG_RISING;
      valid_q <= 1'b0;
      boot_q  <= 1'b1;
    end else begin
      valid_q <= sample_ready_i;
      boot_q  <= 1'b0;
      if (sample_ready_i) begin
        prev_q <= curr_q;
        curr_q <= sample_i;
      end
      if (boot_q || cfg_load_i) begin
        thr_q  <= trig_threshold_i;
        mode_q <= trig_mode_i;
      end
    end
  end

  always_comb begin
    prev_above = (prev_q >= thr_q);
    curr_above = (curr_q >= thr_q);
    case (mode_q)
      TRIG_FALLING: edge_hit = prev_above && !curr_above;
      TRIG_FREE:    edge_hit = 1'b1;
      default:      edge_hit = !prev_above && curr_above;
    endcase
  end

  assign sample_valid_o = valid_q;
  assign trig_hit_o     = valid_q && edge_hit;
  assign curr_o         = curr_q;

endmodule
`default_nettype wire

// File: rtl/trig_wave_capture.sv
`default_nettype none
// ============================================================================
// trig_wave_capture : triggered ping-pong frame capture into a dual-bank RAM
// Rev 1.0
// ============================================================================
module trig_wave_capture
  import trig_wave_capture_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int OUT_W        = 8,
  parameter int ADDR_W       = 8,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               reset_n,
  trig_wave_capture_if.master bus
);

  localparam int                TCNT_W   = cnt_width(AUTO_TIMEOUT);
  localparam bit                AUTO_EN  = (AUTO_TIMEOUT != 0);
  localparam logic [TCNT_W-1:0] TMO_LAST =
    TCNT_W'((AUTO_TIMEOUT == 0) ? 0 : AUTO_TIMEOUT - 1);

  cap_state_e                 state_q;
  logic [ADDR_W-1:0]          index_q;
  logic [TCNT_W-1:0]          tcount_q;
  logic                       read_index_q;
  logic                       write_enable_q;
  logic [ADDR_W:0]            write_address_q;
  logic [OUT_W-1:0]           write_sample_q;
  logic                       frame_done_q;
  logic                       auto_triggered_q;

  logic                       sample_valid, trig_hit, timeout_hit, cfg_load;
  logic signed [SAMPLE_W-1:0] curr;
  logic [OUT_W-1:0]           store_d;

  assign cfg_load    = (state_q == ST_WAIT) && bus.wave_display_idle;
  assign timeout_hit = AUTO_EN && (tcount_q == TMO_LAST) && bus.capture_en;
  // Offset-binary truncation: flip the sign bit, keep the top OUT_W bits
  assign store_d     = {~curr[SAMPLE_W-1], curr[SAMPLE_W-2 -: OUT_W-1]};

  trig_wave_capture_trigger_detect #(
    .SAMPLE_W (SAMPLE_W)
  ) u_trig (
    .clk              (clk),
    .reset_n          (reset_n),
    .sample_ready_i   (bus.new_sample_ready),
    .sample_i         (bus.new_sample_in),
    .cfg_load_i       (cfg_load),
    .trig_mode_i      (bus.trig_mode),
    .trig_threshold_i (bus.trig_threshold),
    .sample_valid_o   (sample_valid),
    .trig_hit_o       (trig_hit),
    .curr_o           (curr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_ARMED;
      index_q          <= '0;
      tcount_q         <= '0;
      read_index_q     <= 1'b0;
      write_enable_q   <= 1'b0;
      write_address_q  <= '0;
      write_sample_q   <= '0;
      frame_done_q     <= 1'b0;
      auto_triggered_q <= 1'b0;
    end else begin
      write_enable_q <= 1'b0;
      frame_done_q   <= 1'b0;
      case (state_q)
        ST_ARMED: begin
          if (!bus.capture_en) begin
            tcount_q <= '0;
          end else if (sample_valid) begin
            if (trig_hit || timeout_hit) begin
              state_q          <= ST_ACTIVE;
              write_enable_q   <= 1'b1;
              write_address_q  <= {~read_index_q, index_q};
              write_sample_q   <= store_d;
              index_q          <= index_q + ADDR_W'(1);
              tcount_q         <= '0;
              auto_triggered_q <= !trig_hit;
            end else begin
              tcount_q <= tcount_q + TCNT_W'(1);
            end
          end
        end
        ST_ACTIVE: begin
          if (sample_valid) begin
            write_enable_q  <= 1'b1;
            write_address_q <= {~read_index_q, index_q};
            write_sample_q  <= store_d;
            index_q         <= index_q + ADDR_W'(1);
            if (index_q == {ADDR_W{1'b1}}) begin
              state_q      <= ST_WAIT;
              frame_done_q <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (bus.wave_display_idle) begin
            read_index_q <= ~read_index_q;
            index_q      <= '0;
            tcount_q     <= '0;
            state_q      <= ST_ARMED;
          end
        end
        default: state_q <= ST_ARMED;
      endcase
    end
  end

  assign bus.write_enable   = write_enable_q;
  assign bus.write_address  = write_address_q;
  assign bus.write_sample   = write_sample_q;
  assign bus.read_index     = read_index_q;
  assign bus.frame_done     = frame_done_q;
  assign bus.auto_triggered = auto_triggered_q;

endmodule
`default_nettype wire

// File: tb/tb_trig_wave_capture.sv
`default_nettype none
// ============================================================================
// tb_trig_wave_capture : directed checks, ADDR_W=4, AUTO_TIMEOUT=8
// Rev 1.0
// ============================================================================
module tb_trig_wave_capture;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  trig_wave_capture_if #(.SAMPLE_W(16), .OUT_W(8), .ADDR_W(4)) bus ();

  trig_wave_capture #(
    .SAMPLE_W(16), .OUT_W(8), .ADDR_W(4), .AUTO_TIMEOUT(8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic       fd;
    logic [4:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t wr_q[$];
  int  fd_count = 0;
  int  n_checks = 0;
  int  n_fail   = 0;

  always @(negedge clk) begin
    if (bus.write_enable) wr_q.push_back({bus.frame_done, bus.write_address, bus.write_sample});
    if (bus.frame_done) fd_count++;
  end

  // Offset-binary top byte: add half range, keep bits [15:8]
  function automatic logic [7:0] exp_data(input int s);
    int u;
    u = s + 32768;
    return 8'((u >> 8) & 255);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    bus.new_sample_in    = 16'(v);
    bus.new_sample_ready = 1'b1;
    tick();
    bus.new_sample_ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic apply_reset(input logic [1:0] mode, input int thr, input logic en);
    reset_n            = 1'b0;
    bus.trig_mode      = mode;
    bus.trig_threshold = 16'(thr);
    bus.capture_en     = en;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    int base;
    logic [17:0] outs;
    reset_n = 1'b0;
    #1;
    outs = {bus.write_enable, bus.write_address, bus.write_sample, bus.read_index,
            bus.frame_done, bus.auto_triggered};
    n_checks++;
    if (outs !== 18'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    apply_reset(2'b00, 0, 1'b1);
    send(-5);
    send(3);
    send(7);
    // third write in flight; reset lands while write_enable is high
    bus.new_sample_in = 16'(100); bus.new_sample_ready = 1'b1;
    tick();
    bus.new_sample_ready = 1'b0;
    tick();
    n_checks++;
    if (bus.write_enable !== 1'b1) begin n_fail++; $display("FAIL midframe_we_pre: got %b expected 1", bus.write_enable); end
    reset_n = 1'b0;
    #1;
    outs = {bus.write_enable, bus.write_address, bus.write_sample, bus.read_index,
            bus.frame_done, bus.auto_triggered};
    n_checks++;
    if (outs !== 18'h0) begin n_fail++; $display("FAIL midframe_reset_outputs: got %h expected 0", outs); end
    tick();
    reset_n = 1'b1;
    tick();
    base = wr_q.size();
    send(-5);
    send(3);
    n_checks++;
    if (wr_q.size() !== base + 1) begin
      n_fail++; $display("FAIL rearm_write_count: got %0d expected %0d", wr_q.size() - base, 1);
    end else begin
      n_checks++;
      if (wr_q[base].addr !== 5'h10) begin n_fail++; $display("FAIL rearm_addr: got %h expected 10", wr_q[base].addr); end
    end
  endtask

  task automatic test_rising();
    int base, fdb, v;
    apply_reset(2'b00, 0, 1'b1);
    base = wr_q.size();
    fdb  = fd_count;
    send(-5);
    send(-1);
    n_checks++;
    if (wr_q.size() !== base) begin n_fail++; $display("FAIL rise_no_early_write: got %0d expected 0", wr_q.size() - base); end
    send(3);
    n_checks++;
    if (wr_q.size() !== base + 1) begin
      n_fail++; $display("FAIL rise_first_write: got %0d writes expected 1", wr_q.size() - base);
    end else begin
      n_checks++;
      if ({wr_q[base].addr, wr_q[base].data} !== {5'h10, 8'h80}) begin
        n_fail++; $display("FAIL rise_first_addr_data: got %h/%h expected 10/80", wr_q[base].addr, wr_q[base].data);
      end
    end
    n_checks++;
    if (bus.auto_triggered !== 1'b0) begin n_fail++; $display("FAIL rise_auto_flag: got %b expected 0", bus.auto_triggered); end
    for (int k = 1; k < 16; k++) send(k * 1000 - 7000);
    n_checks++;
    if (wr_q.size() !== base + 16) begin
      n_fail++; $display("FAIL rise_frame_len: got %0d expected 16", wr_q.size() - base);
    end else begin
      for (int k = 1; k < 16; k++) begin
        v = k * 1000 - 7000;
        n_checks++;
        if ({wr_q[base+k].addr, wr_q[base+k].data} !== {5'(16 + k), exp_data(v)}) begin
          n_fail++; $display("FAIL rise_write_%0d: got %h/%h expected %h/%h", k,
                              wr_q[base+k].addr, wr_q[base+k].data, 5'(16 + k), exp_data(v));
        end
      end
      n_checks++;
      if (wr_q[base+15].fd !== 1'b1) begin n_fail++; $display("FAIL rise_fd_on_last: got %b expected 1", wr_q[base+15].fd); end
    end
    n_checks++;
    if (fd_count - fdb !== 1) begin n_fail++; $display("FAIL rise_fd_count: got %0d expected 1", fd_count - fdb); end
  endtask

  task automatic test_wait_idle_low();
    int base;
    base = wr_q.size();
    send(500);
    send(800);
    send(-300);
    n_checks++;
    if (wr_q.size() !== base) begin n_fail++; $display("FAIL wait_no_writes: got %0d expected 0", wr_q.size() - base); end
    n_checks++;
    if (bus.read_index !== 1'b0) begin n_fail++; $display("FAIL wait_read_index: got %b expected 0", bus.read_index); end
  endtask

  task automatic test_handover();
    int base, bad;
    bus.wave_display_idle = 1'b1;
    tick();
    bus.wave_display_idle = 1'b0;
    n_checks++;
    if (bus.read_index !== 1'b1) begin n_fail++; $display("FAIL handover_read_index: got %b expected 1", bus.read_index); end
    base = wr_q.size();
    // -300 from WAIT is prev; 50 completes a rising edge across the handover
    send(50);
    for (int k = 1; k < 16; k++) send(k * 37);
    bad = 0;
    n_checks++;
    if (wr_q.size() !== base + 16) begin
      n_fail++; $display("FAIL handover_frame_len: got %0d expected 16", wr_q.size() - base);
    end else begin
      for (int k = 0; k < 16; k++) if (wr_q[base+k].addr !== 5'(k)) bad++;
      n_checks++;
      if (bad !== 0) begin n_fail++; $display("FAIL handover_addrs: got %0d bad addresses expected 0", bad); end
    end
  endtask

  task automatic test_back_to_back();
    int base, v;
    bus.trig_mode = 2'b10;
    bus.wave_display_idle = 1'b1;
    tick();
    bus.wave_display_idle = 1'b0;
    n_checks++;
    if (bus.read_index !== 1'b0) begin n_fail++; $display("FAIL b2b_read_index: got %b expected 0", bus.read_index); end
    base = wr_q.size();
    for (int i = 0; i < 16; i++) begin
      bus.new_sample_in    = 16'(i * 4096 - 30000);
      bus.new_sample_ready = 1'b1;
      tick();
    end
    bus.new_sample_ready = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (wr_q.size() !== base + 16) begin
      n_fail++; $display("FAIL b2b_count: got %0d expected 16", wr_q.size() - base);
    end else begin
      for (int i = 0; i < 16; i++) begin
        v = i * 4096 - 30000;
        n_checks++;
        if ({wr_q[base+i].addr, wr_q[base+i].data} !== {5'(16 + i), exp_data(v)}) begin
          n_fail++; $display("FAIL b2b_write_%0d: got %h/%h expected %h/%h", i,
                              wr_q[base+i].addr, wr_q[base+i].data, 5'(16 + i), exp_data(v));
        end
      end
      n_checks++;
      if (wr_q[base+15].fd !== 1'b1) begin n_fail++; $display("FAIL b2b_fd_last: got %b expected 1", wr_q[base+15].fd); end
    end
  endtask

  task automatic test_falling();
    int base;
    apply_reset(2'b01, 100, 1'b1);
    bus.trig_threshold = 16'(0);
    bus.trig_mode      = 2'b00;
    base = wr_q.size();
    send(200);
    send(150);
    send(120);
    n_checks++;
    if (wr_q.size() !== base) begin n_fail++; $display("FAIL fall_no_trigger: got %0d writes expected 0", wr_q.size() - base); end
    send(99);
    n_checks++;
    if (wr_q.size() !== base + 1) begin
      n_fail++; $display("FAIL fall_trigger: got %0d writes expected 1", wr_q.size() - base);
    end else begin
      n_checks++;
      if ({wr_q[base].addr, wr_q[base].data} !== {5'h10, 8'h80}) begin
        n_fail++; $display("FAIL fall_addr_data: got %h/%h expected 10/80", wr_q[base].addr, wr_q[base].data);
      end
    end
  endtask

  task automatic test_auto();
    int base;
    apply_reset(2'b00, 0, 1'b0);
    base = wr_q.size();
    for (int i = 0; i < 20; i++) send(0);
    n_checks++;
    if (wr_q.size() !== base) begin n_fail++; $display("FAIL auto_disabled: got %0d writes expected 0", wr_q.size() - base); end
    bus.capture_en = 1'b1;
    for (int i = 0; i < 7; i++) send(0);
    n_checks++;
    if (wr_q.size() !== base) begin n_fail++; $display("FAIL auto_early: got %0d writes expected 0", wr_q.size() - base); end
    send(0);
    n_checks++;
    if (wr_q.size() !== base + 1) begin
      n_fail++; $display("FAIL auto_fire: got %0d writes expected 1", wr_q.size() - base);
    end else begin
      n_checks++;
      if ({wr_q[base].addr, wr_q[base].data} !== {5'h10, 8'h80}) begin
        n_fail++; $display("FAIL auto_addr_data: got %h/%h expected 10/80", wr_q[base].addr, wr_q[base].data);
      end
    end
    n_checks++;
    if (bus.auto_triggered !== 1'b1) begin n_fail++; $display("FAIL auto_flag: got %b expected 1", bus.auto_triggered); end
  endtask

  initial begin
    bus.capture_en        = 1'b1;
    bus.trig_mode         = 2'b00;
    bus.trig_threshold    = '0;
    bus.new_sample_ready  = 1'b0;
    bus.new_sample_in     = '0;
    bus.wave_display_idle = 1'b0;
    test_reset();
    test_rising();
    test_wait_idle_low();
    test_handover();
    test_back_to_back();
    test_falling();
    test_auto();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
